// File: rtl/drawer_pkg.sv
// Shared definitions for the drawer phase controller: phase encodings,
// internal state set and default datapath widths.
package drawer_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_LOAD = 3'd1,
        PH_SET1 = 3'd2,
        PH_CMP  = 3'd3,
        PH_SET2 = 3'd4,
        PH_DRAW = 3'd5
    } phase_e;

    // S_LAST is the cycle carrying the final memory 1/2 write; it still reports as LOAD.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_LAST = 3'd2,
        S_SET1 = 3'd3,
        S_CMP  = 3'd4,
        S_SET2 = 3'd5,
        S_DRAW = 3'd6
    } seq_state_e;

    function automatic phase_e phaseOf(input seq_state_e s);
        case (s)
            S_IDLE:  phaseOf = PH_IDLE;
            S_LOAD:  phaseOf = PH_LOAD;
            S_LAST:  phaseOf = PH_LOAD;
            S_SET1:  phaseOf = PH_SET1;
            S_CMP:   phaseOf = PH_CMP;
            S_SET2:  phaseOf = PH_SET2;
            S_DRAW:  phaseOf = PH_DRAW;
            default: phaseOf = PH_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/drawer_sequencer_hold_counter.sv
// Loadable down-counter that parks at zero; terminal flags the last cycle
// of a hold interval that was loaded with (length - 1).
module seq_hold_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] loadValue,
    output logic             terminal
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count_r;

    // Count register: load wins, otherwise decrement until zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= loadValue;
        end else if (count_r != '0) begin
            count_r <= count_r - ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign terminal = (count_r == '0);

endmodule

// File: rtl/drawer_sequencer.sv
// Phase controller for the drawer: loads memories 1/2, sweeps the compare pass
// writing memory 3, then holds the draw enable until aborted.
module drawer_sequencer
    import drawer_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DEPTH        = 16,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int COMPARE_HOLD = 2,
    parameter int SETTLE       = 2
) (
    input  logic              clk50,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data1,
    input  logic [DATA_W-1:0] in_data2,
    output logic              enable,
    output logic [ADDR_W-1:0] address,
    output logic              wren1,
    output logic [DATA_W-1:0] data1,
    output logic              wren2,
    output logic [DATA_W-1:0] data2,
    output logic              wren3,
    output logic              busy,
    output logic [2:0]        phase
);

    localparam int HOLD_MAX = (SETTLE > COMPARE_HOLD) ? SETTLE : COMPARE_HOLD;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [HOLD_W-1:0] SETTLE_LD = HOLD_W'(SETTLE - 1);
    localparam logic [HOLD_W-1:0] CMP_LD    = HOLD_W'(COMPARE_HOLD - 1);

    seq_state_e        state_r,   nextState_s;
    logic [ADDR_W-1:0] wordCnt_r, nextWord_s;
    logic [ADDR_W-1:0] address_r, nextAddr_s;
    logic [DATA_W-1:0] data1_r,   nextData1_s;
    logic [DATA_W-1:0] data2_r,   nextData2_s;
    logic              wren12_r,  nextWren12_s;
    logic              wren3_r,   nextWren3_s;
    logic              enable_r,  nextEnable_s;
    logic              inReady_r, nextReady_s;
    logic              busy_r;
    phase_e            phase_r;

    logic              beat_s;
    logic              holdLoad_s;
    logic [HOLD_W-1:0] holdValue_s;
    logic              holdTerm_s;

    seq_hold_counter #(
        .WIDTH(HOLD_W)
    ) u_hold (
        .clk      (clk50),
        .reset    (reset),
        .load     (holdLoad_s),
        .loadValue(holdValue_s),
        .terminal (holdTerm_s)
    );

    assign beat_s = in_valid & inReady_r;

    // Next-state and next-output decode; every output register is fed from here.
    always_comb begin
        nextState_s  = state_r;
        nextWord_s   = wordCnt_r;
        nextAddr_s   = address_r;
        nextData1_s  = data1_r;
        nextData2_s  = data2_r;
        nextWren12_s = 1'b0;
        nextWren3_s  = 1'b0;
        nextEnable_s = 1'b0;
        nextReady_s  = 1'b0;
        holdLoad_s   = 1'b0;
        holdValue_s  = '0;

        case (state_r)
            S_IDLE: begin
                if (start && !abort) begin
                    nextState_s = S_LOAD;
                    nextWord_s  = '0;
                    nextReady_s = 1'b1;
                end else begin
                    nextState_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else if (beat_s) begin
                    nextAddr_s   = wordCnt_r;
                    nextData1_s  = in_data1;
                    nextData2_s  = in_data2;
                    nextWren12_s = 1'b1;
                    // Terminal word leaves LOAD without ever incrementing past DEPTH-1.
                    if (wordCnt_r == LAST_ADDR) begin
                        nextState_s = S_LAST;
                    end else begin
                        nextWord_s  = wordCnt_r + ADDR_ONE;
                        nextReady_s = 1'b1;
                    end
                end else begin
                    nextReady_s = 1'b1;
                end
            end
            S_LAST: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else begin
                    nextState_s = S_SET1;
                    holdLoad_s  = 1'b1;
                    holdValue_s = SETTLE_LD;
                end
            end
            S_SET1: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else if (holdTerm_s) begin
                    nextState_s = S_CMP;
                    nextAddr_s  = '0;
                    nextWren3_s = 1'b1;
                    holdLoad_s  = 1'b1;
                    holdValue_s = CMP_LD;
                end else begin
                    nextState_s = S_SET1;
                end
            end
            S_CMP: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else if (holdTerm_s) begin
                    if (address_r == LAST_ADDR) begin
                        nextState_s = S_SET2;
                        holdLoad_s  = 1'b1;
                        holdValue_s = SETTLE_LD;
                    end else begin
                        nextAddr_s  = address_r + ADDR_ONE;
                        nextWren3_s = 1'b1;
                        holdLoad_s  = 1'b1;
                        holdValue_s = CMP_LD;
                    end
                end else begin
                    nextWren3_s = 1'b1;
                end
            end
            S_SET2: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else if (holdTerm_s) begin
                    nextState_s  = S_DRAW;
                    nextAddr_s   = '0;
                    nextEnable_s = 1'b1;
                end else begin
                    nextState_s = S_SET2;
                end
            end
            S_DRAW: begin
                if (abort) begin
                    nextState_s = S_IDLE;
                end else begin
                    nextEnable_s = 1'b1;
                end
            end
            default: begin
                nextState_s = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_r   <= S_IDLE;
            wordCnt_r <= '0;
            address_r <= '0;
            data1_r   <= '0;
            data2_r   <= '0;
            wren12_r  <= 1'b0;
            wren3_r   <= 1'b0;
            enable_r  <= 1'b0;
            inReady_r <= 1'b0;
            busy_r    <= 1'b0;
            phase_r   <= PH_IDLE;
        end else begin
            state_r   <= nextState_s;
            wordCnt_r <= nextWord_s;
            address_r <= nextAddr_s;
            data1_r   <= nextData1_s;
            data2_r   <= nextData2_s;
            wren12_r  <= nextWren12_s;
            wren3_r   <= nextWren3_s;
            enable_r  <= nextEnable_s;
            inReady_r <= nextReady_s;
            busy_r    <= (nextState_s != S_IDLE);
            phase_r   <= phaseOf(nextState_s);
        end
    end

    assign in_ready = inReady_r;
    assign enable   = enable_r;
    assign address  = address_r;
    assign wren1    = wren12_r;
    assign wren2    = wren12_r;
    assign data1    = data1_r;
    assign data2    = data2_r;
    assign wren3    = wren3_r;
    assign busy     = busy_r;
    assign phase    = phase_r;

endmodule
